// File: rtl/snake_pkg.sv
// Shared encodings for the snake step controller: headings, master game
// states, the internal control FSM states and the reversal check.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_PLAY = 2'b01,
    MS_WIN  = 2'b10
  } master_state_t;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'b00,
    CTRL_RUN  = 2'b01,
    CTRL_DONE = 2'b10
  } ctrl_state_t;

  // Two headings are opposite exactly when they differ only in the MSB.
  function automatic logic is_reverse(input logic [1:0] cand,
                                      input logic [1:0] ref_dir);
    return ((cand ^ ref_dir) == 2'b10);
  endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Step timer: counts 0..TICK_PERIOD-1 while enabled, clears and holds
// otherwise. TICK is a registered one-cycle pulse emitted on the edge that
// leaves the last count, so it is high one cycle after the counter
// reaches TICK_PERIOD-1.
module snake_step_timer #(
  parameter int TICK_PERIOD = 25_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  output logic TICK
);

  localparam int CW = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count and pulse; a disabled timer returns to zero.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (EN) begin
      tick_d = (cnt_q == LAST);
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign TICK = tick_q;

endmodule

// File: rtl/snake_step_ctrl.sv
// Snake step controller: paces snake steps, filters direction buttons
// (no reversals), counts targets eaten and raises FINISHED on a win.
// The STEP output is the timer's registered pulse; the cycle in which
// STEP is high is the "step cycle": DIRECTION loads the pending heading
// on the edge closing that cycle, and a button seen in that cycle is
// checked against the pending heading (the heading about to be applied).
// FSM_STATE exposes the internal control FSM for observation.
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_PERIOD = 25_000_000,
  parameter int WIN_SCORE   = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] STATE,
  input  logic       BTN_U,
  input  logic       BTN_D,
  input  logic       BTN_L,
  input  logic       BTN_R,
  input  logic       TARGET_HIT,
  output logic [1:0] DIRECTION,
  output logic       STEP,
  output logic       TARGET_REQ,
  output logic [3:0] SCORE,
  output logic       FINISHED,
  output logic [1:0] FSM_STATE
);

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  ctrl_state_t state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic [1:0]  pending_q, pending_d;
  logic [3:0]  score_q, score_d;
  logic        treq_q, treq_d;
  logic        finished_q, finished_d;

  logic        in_play;
  logic        tick;
  logic        cand_vld;
  logic [1:0]  cand;
  logic [1:0]  ref_dir;
  logic        hit_ok;
  logic        win_hit;
  logic [3:0]  score_inc;

  assign in_play = (STATE == MS_PLAY);

  snake_step_timer #(
    .TICK_PERIOD (TICK_PERIOD)
  ) u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (in_play),
    .TICK  (tick)
  );

  // Button priority decode U > D > L > R; buttons count only in IDLE/PLAY.
  always_comb begin
    cand_vld = 1'b0;
    cand     = DIR_UP;
    if (STATE == MS_IDLE || STATE == MS_PLAY) begin
      if (BTN_U) begin
        cand_vld = 1'b1;
        cand     = DIR_UP;
      end else if (BTN_D) begin
        cand_vld = 1'b1;
        cand     = DIR_DOWN;
      end else if (BTN_L) begin
        cand_vld = 1'b1;
        cand     = DIR_LEFT;
      end else if (BTN_R) begin
        cand_vld = 1'b1;
        cand     = DIR_RIGHT;
      end
    end
  end

  // Heading filter: reject reversals against the reference heading and
  // apply the pending heading on a step.
  always_comb begin
    ref_dir   = tick ? pending_q : dir_q;
    pending_d = pending_q;
    if (cand_vld && !is_reverse(cand, ref_dir)) begin
      pending_d = cand;
    end
    dir_d = tick ? pending_q : dir_q;
  end

  // Score update: one increment per accepted hit, request a new target
  // unless this hit wins the game.
  always_comb begin
    score_inc  = score_q + 4'd1;
    hit_ok     = TARGET_HIT && in_play && !finished_q;
    win_hit    = hit_ok && (score_inc == WIN);
    score_d    = hit_ok ? score_inc : score_q;
    treq_d     = hit_ok && !win_hit;
    finished_d = finished_q || win_hit;
  end

  // Control FSM next state; DONE is left only through RESET.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_IDLE: begin
        if (win_hit)      state_d = CTRL_DONE;
        else if (in_play) state_d = CTRL_RUN;
      end
      CTRL_RUN: begin
        if (win_hit)       state_d = CTRL_DONE;
        else if (!in_play) state_d = CTRL_IDLE;
      end
      CTRL_DONE: state_d = CTRL_DONE;
      default:   state_d = CTRL_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= CTRL_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers; RESET overrides every other input.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dir_q      <= DIR_RIGHT;
      pending_q  <= DIR_RIGHT;
      score_q    <= 4'd0;
      treq_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      pending_q  <= pending_d;
      score_q    <= score_d;
      treq_q     <= treq_d;
      finished_q <= finished_d;
    end
  end

  assign DIRECTION  = dir_q;
  assign STEP       = tick;
  assign TARGET_REQ = treq_q;
  assign SCORE      = score_q;
  assign FINISHED   = finished_q;
  assign FSM_STATE  = state_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl with TICK_PERIOD=4, WIN_SCORE=3.
// Cycle numbering: cycle 0 is the first cycle with STATE=PLAY; outputs
// are sampled 1 time unit after each rising edge, inputs driven there.
module tb_snake_step_ctrl;

  localparam int TP = 4;
  localparam int WS = 3;

  logic       CLK;
  logic       RESET;
  logic [1:0] STATE;
  logic       BTN_U, BTN_D, BTN_L, BTN_R;
  logic       TARGET_HIT;
  logic [1:0] DIRECTION;
  logic       STEP;
  logic       TARGET_REQ;
  logic [3:0] SCORE;
  logic       FINISHED;
  logic [1:0] FSM_STATE;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit step_chk_en = 0;
  bit dir_chk     = 0;

  // Expected {SCORE, TARGET_REQ, FINISHED} one cycle after each driven hit.
  logic [5:0] exp_q[$];
  // Expected DIRECTION in the cycle after each STEP.
  logic [1:0] dir_q[$];

  snake_step_ctrl #(
    .TICK_PERIOD (TP),
    .WIN_SCORE   (WS)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .STATE      (STATE),
    .BTN_U      (BTN_U),
    .BTN_D      (BTN_D),
    .BTN_L      (BTN_L),
    .BTN_R      (BTN_R),
    .TARGET_HIT (TARGET_HIT),
    .DIRECTION  (DIRECTION),
    .STEP       (STEP),
    .TARGET_REQ (TARGET_REQ),
    .SCORE      (SCORE),
    .FINISHED   (FINISHED),
    .FSM_STATE  (FSM_STATE)
  );

  // Clock and watchdog.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, run scoreboard comparisons, release pulse inputs.
  task automatic tick();
    logic [5:0] e;
    logic [1:0] d;
    @(posedge CLK);
    #1;
    cyc++;
    if (dir_chk) begin
      d = dir_q.pop_front();
      check("direction_after_step", {6'd0, DIRECTION}, {6'd0, d});
      dir_chk = 0;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("score_treq_finished", {2'd0, SCORE, TARGET_REQ, FINISHED}, {2'd0, e});
    end
    if (step_chk_en) check("step_timing", {7'd0, STEP}, {7'd0, (cyc % TP) == 0});
    if (STEP) begin
      if (dir_q.size() > 0) dir_chk = 1;
      else check("unexpected_step", {7'd0, STEP}, 8'd0);
    end
    BTN_U = 0; BTN_D = 0; BTN_L = 0; BTN_R = 0;
    TARGET_HIT = 0;
  endtask

  initial begin
    RESET = 1; STATE = 2'b00;
    BTN_U = 0; BTN_D = 0; BTN_L = 0; BTN_R = 0; TARGET_HIT = 0;
    tick(); tick();
    check("rst_direction", {6'd0, DIRECTION}, 8'h01);
    check("rst_step", {7'd0, STEP}, 8'd0);
    check("rst_treq", {7'd0, TARGET_REQ}, 8'd0);
    check("rst_score", {4'd0, SCORE}, 8'd0);
    check("rst_finished", {7'd0, FINISHED}, 8'd0);
    check("rst_fsm", {6'd0, FSM_STATE}, 8'd0);
    RESET = 0;
    tick();

    // Steady play: STEP at 4, 8, 12; heading stays RIGHT.
    STATE = 2'b01; cyc = 0; step_chk_en = 1;
    dir_q.push_back(2'b01); dir_q.push_back(2'b01); dir_q.push_back(2'b01);
    repeat (12) tick();
    check("fsm_run", {6'd0, FSM_STATE}, 8'h01);

    // LEFT while heading RIGHT is a reversal and is dropped.
    tick();                                   // 13
    BTN_L = 1; dir_q.push_back(2'b01);
    repeat (4) tick();                        // 17

    // UP accepted, then LEFT checked against DIRECTION=RIGHT and dropped.
    BTN_U = 1; tick();                        // 18
    BTN_L = 1; dir_q.push_back(2'b00); tick();// 19
    repeat (2) tick();                        // 21

    // Pending RIGHT; LEFT in the step cycle is checked against pending.
    dir_q.push_back(2'b01); dir_q.push_back(2'b01);
    tick();                                   // 22
    BTN_R = 1; tick();                        // 23
    tick();                                   // 24 (STEP)
    BTN_L = 1;
    repeat (5) tick();                        // 29

    // Priority: DOWN beats RIGHT.
    BTN_D = 1; BTN_R = 1; dir_q.push_back(2'b10);
    repeat (4) tick();                        // 33

    // Scoring up to the win, last hit coincident with STEP.
    TARGET_HIT = 1; exp_q.push_back({4'd1, 1'b1, 1'b0}); tick();  // 34
    BTN_L = 1; dir_q.push_back(2'b11); tick();                    // 35
    check("treq_single_cycle", {7'd0, TARGET_REQ}, 8'd0);
    TARGET_HIT = 1; exp_q.push_back({4'd2, 1'b1, 1'b0}); tick();  // 36 (STEP)
    TARGET_HIT = 1; exp_q.push_back({4'd3, 1'b0, 1'b1}); tick();  // 37
    TARGET_HIT = 1; exp_q.push_back({4'd3, 1'b0, 1'b1}); tick();  // 38
    check("fsm_done", {6'd0, FSM_STATE}, 8'h02);

    // WIN state: hits ignored, no steps, FINISHED held.
    STATE = 2'b10; step_chk_en = 0; TARGET_HIT = 1;
    repeat (4) tick();
    check("win_score_hold", {4'd0, SCORE}, 8'd3);
    check("win_finished_hold", {7'd0, FINISHED}, 8'd1);
    check("win_no_step", {7'd0, STEP}, 8'd0);
    check("win_fsm_done", {6'd0, FSM_STATE}, 8'h02);

    // RESET beats a pending STEP, hit and button.
    RESET = 1; tick();
    RESET = 0; STATE = 2'b01; cyc = 0;
    tick();                                   // 1
    TARGET_HIT = 1; exp_q.push_back({4'd1, 1'b1, 1'b0}); tick(); // 2
    tick();                                   // 3
    RESET = 1; TARGET_HIT = 1; BTN_U = 1;
    tick();                                   // 4
    check("rst2_step", {7'd0, STEP}, 8'd0);
    check("rst2_treq", {7'd0, TARGET_REQ}, 8'd0);
    check("rst2_score", {4'd0, SCORE}, 8'd0);
    check("rst2_finished", {7'd0, FINISHED}, 8'd0);
    check("rst2_direction", {6'd0, DIRECTION}, 8'h01);
    check("rst2_fsm", {6'd0, FSM_STATE}, 8'h00);
    RESET = 0; cyc = 0; step_chk_en = 1; dir_q.push_back(2'b01);
    repeat (5) tick();
    check("rst2_fsm_run", {6'd0, FSM_STATE}, 8'h01);

    // Preset heading in IDLE; reversal check uses DIRECTION there.
    RESET = 1; STATE = 2'b00; step_chk_en = 0; tick();
    RESET = 0; tick();
    BTN_D = 1; tick();
    BTN_L = 1; tick();
    STATE = 2'b01; cyc = 0; step_chk_en = 1; dir_q.push_back(2'b10);
    repeat (5) tick();

    check("dir_queue_drained", dir_q.size() > 0 ? 8'd1 : 8'd0, {7'd0, dir_chk});
    check("score_queue_drained", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
